// File: rtl/maze_pkg.sv
// Shared types and helpers for the maze wall follower.
// Cell (x,y) lives at bit x+16*y of the flat bitmap.
package maze_pkg;

    localparam int MAZE_DIM  = 16;
    localparam int CELL_BITS = 256;

    typedef enum logic {
        WALL = 1'b0,
        PATH = 1'b1
    } cell_e;

    typedef enum logic [1:0] {
        HDG_N = 2'd0,
        HDG_E = 2'd1,
        HDG_S = 2'd2,
        HDG_W = 2'd3
    } heading_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_EMIT,
        ST_STEP,
        ST_DONE,
        ST_FAIL
    } state_e;

    function automatic logic [7:0] cell_index(
        input logic [3:0] x,
        input logic [3:0] y
    );
        return {y, x};
    endfunction

    function automatic logic [3:0] next_x(
        input logic [3:0] x,
        input heading_e   h
    );
        logic [3:0] r;
        r = x;
        if (h == HDG_E) r = x + 4'd1;
        if (h == HDG_W) r = x - 4'd1;
        return r;
    endfunction

    function automatic logic [3:0] next_y(
        input logic [3:0] y,
        input heading_e   h
    );
        logic [3:0] r;
        r = y;
        if (h == HDG_S) r = y + 4'd1;
        if (h == HDG_N) r = y - 4'd1;
        return r;
    endfunction

    // The outer ring is wall regardless of the bitmap contents.
    function automatic logic is_blocked(
        input logic [CELL_BITS-1:0] map,
        input logic [3:0]           x,
        input logic [3:0]           y
    );
        logic edge_c;
        edge_c = (x == 4'd0) || (x == 4'(MAZE_DIM - 1)) ||
                 (y == 4'd0) || (y == 4'(MAZE_DIM - 1));
        return edge_c || (cell_e'(map[cell_index(x, y)]) == WALL);
    endfunction

endpackage

// File: rtl/maze_neighbor_sel.sv
// Right-hand-rule move selection: right, straight, left, back.
// Purely combinational; reports none_open for an isolated cell.
module maze_neighbor_sel
    import maze_pkg::*;
(
    input  logic [CELL_BITS-1:0] map_i,
    input  logic [3:0]           pos_x_i,
    input  logic [3:0]           pos_y_i,
    input  heading_e             hdg_i,
    output logic [3:0]           nxt_x_o,
    output logic [3:0]           nxt_y_o,
    output heading_e             nxt_hdg_o,
    output logic                 none_open_o
);

    // Turn offsets in priority order, packed LSB first: +1, +0, +3, +2.
    localparam logic [7:0] TURNS = {2'd2, 2'd3, 2'd0, 2'd1};

    heading_e   cand_h [4];
    logic [3:0] cand_x [4];
    logic [3:0] cand_y [4];
    logic       cand_ok[4];

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            cand_h[k]  = heading_e'(hdg_i + TURNS[2*k +: 2]);
            cand_x[k]  = next_x(pos_x_i, cand_h[k]);
            cand_y[k]  = next_y(pos_y_i, cand_h[k]);
            cand_ok[k] = !is_blocked(map_i, cand_x[k], cand_y[k]);
        end
    end

    // Walk lowest priority first so the highest open candidate wins.
    always_comb begin
        nxt_x_o     = pos_x_i;
        nxt_y_o     = pos_y_i;
        nxt_hdg_o   = hdg_i;
        none_open_o = 1'b1;
        for (int k = 3; k >= 0; k--) begin
            if (cand_ok[k]) begin
                nxt_x_o     = cand_x[k];
                nxt_y_o     = cand_y[k];
                nxt_hdg_o   = cand_h[k];
                none_open_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/maze_wall_follower.sv
// Right-hand wall follower over a snapshot of the carver bitmap.
// Define MAZE_TRACE_MAP_EN to add the visited_map output.
module maze_wall_follower
    import maze_pkg::*;
#(
    parameter int MAX_STEPS = 1023,
    parameter int START_X   = 1,
    parameter int START_Y   = 1,
    parameter int START_DIR = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [CELL_BITS-1:0] maze_data,
    input  logic [3:0]           goal_x,
    input  logic [3:0]           goal_y,
    output logic [3:0]           pos_x,
    output logic [3:0]           pos_y,
    output logic                 pos_valid,
    input  logic                 pos_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 fail,
    output logic [9:0]           step_count
`ifdef MAZE_TRACE_MAP_EN
    ,
    output logic [CELL_BITS-1:0] visited_map
`endif
);

    localparam logic [9:0] MAX_Q     = 10'(MAX_STEPS);
    localparam logic [3:0] START_XQ  = 4'(START_X);
    localparam logic [3:0] START_YQ  = 4'(START_Y);
    localparam heading_e   START_HDG = heading_e'(2'(START_DIR));

    state_e               state_q, state_d;
    logic [CELL_BITS-1:0] map_q, map_d;
    logic [3:0]           gx_q, gx_d;
    logic [3:0]           gy_q, gy_d;
    logic [3:0]           px_q, px_d;
    logic [3:0]           py_q, py_d;
    heading_e             hdg_q, hdg_d;
    logic [9:0]           steps_q, steps_d;

    logic [3:0] nx, ny;
    heading_e   nh;
    logic       none_open;
    logic       start_acc;
    logic       hs;

    maze_neighbor_sel u_sel (
        .map_i       (map_q),
        .pos_x_i     (px_q),
        .pos_y_i     (py_q),
        .hdg_i       (hdg_q),
        .nxt_x_o     (nx),
        .nxt_y_o     (ny),
        .nxt_hdg_o   (nh),
        .none_open_o (none_open)
    );

    assign start_acc = start && ((state_q == ST_IDLE) ||
                                 (state_q == ST_DONE) ||
                                 (state_q == ST_FAIL));
    assign hs        = (state_q == ST_EMIT) && pos_ready;

    always_comb begin
        state_d = state_q;
        map_d   = map_q;
        gx_d    = gx_q;
        gy_d    = gy_q;
        px_d    = px_q;
        py_d    = py_q;
        hdg_d   = hdg_q;
        steps_d = steps_q;
        unique case (state_q)
            ST_IDLE, ST_DONE, ST_FAIL: begin
                if (start_acc) begin
                    state_d = ST_LOAD;
                    map_d   = maze_data;
                    gx_d    = goal_x;
                    gy_d    = goal_y;
                    px_d    = START_XQ;
                    py_d    = START_YQ;
                    hdg_d   = START_HDG;
                    steps_d = '0;
                end
            end
            ST_LOAD: begin
                state_d = is_blocked(map_q, px_q, py_q) ? ST_FAIL : ST_EMIT;
            end
            ST_EMIT: begin
                if (hs) begin
                    if (px_q == gx_q && py_q == gy_q) state_d = ST_DONE;
                    else if (steps_q == MAX_Q)       state_d = ST_FAIL;
                    else                             state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                if (none_open) begin
                    state_d = ST_FAIL;
                end else begin
                    state_d = ST_EMIT;
                    px_d    = nx;
                    py_d    = ny;
                    hdg_d   = nh;
                    steps_d = steps_q + 10'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            map_q   <= '0;
            gx_q    <= '0;
            gy_q    <= '0;
            px_q    <= '0;
            py_q    <= '0;
            hdg_q   <= START_HDG;
            steps_q <= '0;
        end else begin
            state_q <= state_d;
            map_q   <= map_d;
            gx_q    <= gx_d;
            gy_q    <= gy_d;
            px_q    <= px_d;
            py_q    <= py_d;
            hdg_q   <= hdg_d;
            steps_q <= steps_d;
        end
    end

    // Valid is masked during reset so nothing handshakes on the reset edge.
    assign pos_valid  = (state_q == ST_EMIT) && rst_n;
    assign busy       = (state_q == ST_LOAD) || (state_q == ST_EMIT) ||
                        (state_q == ST_STEP);
    assign done       = (state_q == ST_DONE);
    assign fail       = (state_q == ST_FAIL);
    assign pos_x      = px_q;
    assign pos_y      = py_q;
    assign step_count = steps_q;

`ifdef MAZE_TRACE_MAP_EN
    logic [CELL_BITS-1:0] vis_q, vis_d;

    always_comb begin
        vis_d = vis_q;
        if (start_acc) vis_d = '0;
        else if (hs)   vis_d[cell_index(px_q, py_q)] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) vis_q <= '0;
        else        vis_q <= vis_d;
    end

    assign visited_map = vis_q;
`endif

endmodule

// File: tb/tb_maze_wall_follower.sv
// Directed self-checking bench for maze_wall_follower.
// Second instance uses MAX_STEPS=8 for the step-limit scenario.
module tb_maze_wall_follower;

    logic         clk = 1'b0;
    logic         rst_n, start, pos_ready;
    logic [255:0] maze_data;
    logic [3:0]   goal_x, goal_y;

    logic [3:0] pos_x, pos_y, pos_x8, pos_y8;
    logic       pos_valid, busy, done, fail;
    logic       pos_valid8, busy8, done8, fail8;
    logic [9:0] step_count, step_count8;
`ifdef MAZE_TRACE_MAP_EN
    logic [255:0] visited_map, visited_map8;
`endif

    int checks = 0;
    int failures = 0;
    logic [7:0] em_q[$];
    logic [7:0] em8_q[$];

    always #5 clk = ~clk;

    maze_wall_follower dut (
        .clk(clk), .rst_n(rst_n), .start(start), .maze_data(maze_data),
        .goal_x(goal_x), .goal_y(goal_y), .pos_x(pos_x), .pos_y(pos_y),
        .pos_valid(pos_valid), .pos_ready(pos_ready), .busy(busy),
        .done(done), .fail(fail), .step_count(step_count)
`ifdef MAZE_TRACE_MAP_EN
        , .visited_map(visited_map)
`endif
    );

    maze_wall_follower #(.MAX_STEPS(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .maze_data(maze_data),
        .goal_x(goal_x), .goal_y(goal_y), .pos_x(pos_x8), .pos_y(pos_y8),
        .pos_valid(pos_valid8), .pos_ready(pos_ready), .busy(busy8),
        .done(done8), .fail(fail8), .step_count(step_count8)
`ifdef MAZE_TRACE_MAP_EN
        , .visited_map(visited_map8)
`endif
    );

    always @(negedge clk) begin
        if (pos_valid && pos_ready)  em_q.push_back({pos_x, pos_y});
        if (pos_valid8 && pos_ready) em8_q.push_back({pos_x8, pos_y8});
    end

    function automatic logic [255:0] set_cell(
        input logic [255:0] m, input int x, input int y);
        m[x + 16*y] = 1'b1;
        return m;
    endfunction

    function automatic logic [255:0] corridor_map();
        logic [255:0] m;
        m = '0;
        for (int x = 1; x <= 14; x++) m = set_cell(m, x, 1);
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; pos_ready = 1'b1;
        maze_data = '0; goal_x = '0; goal_y = '0;
        tick(); tick();
        rst_n = 1'b1;
        em_q.delete(); em8_q.delete();
    endtask

    task automatic pulse_start(input logic [255:0] m,
                               input logic [3:0] gx, input logic [3:0] gy);
        maze_data = m; goal_x = gx; goal_y = gy; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_end(input bit use8, input int budget, output bit to);
        to = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (use8 ? (done8 || fail8) : (done || fail)) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; pos_ready = 1'b1;
        maze_data = '1; goal_x = 4'd3; goal_y = 4'd3;
        tick(); tick();
        @(negedge clk);
        checks++;
        if ({busy, done, fail, pos_valid} !== 4'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=0000",
                     {busy, done, fail, pos_valid});
        end
        checks++;
        if ({pos_x, pos_y} !== 8'h00) begin
            failures++;
            $display("FAIL reset_pos got=%h exp=00", {pos_x, pos_y});
        end
        checks++;
        if (step_count !== 10'd0) begin
            failures++;
            $display("FAIL reset_steps got=%0d exp=0", step_count);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_corridor();
        bit to;
        int bad;
        do_reset();
        pulse_start(corridor_map(), 4'd14, 4'd1);
        @(negedge clk);
        checks++;
        if (pos_valid !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL corr_load got=v%b b%b exp=v0 b1", pos_valid, busy);
        end
        @(negedge clk);
        checks++;
        if (pos_valid !== 1'b1 || {pos_x, pos_y} !== 8'h11) begin
            failures++;
            $display("FAIL corr_first got=v%b %h exp=v1 11",
                     pos_valid, {pos_x, pos_y});
        end
        tick(); tick();
        pulse_start('0, 4'd0, 4'd0);
        wait_end(1'b0, 300, to);
        checks++;
        if (to || done !== 1'b1 || fail !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL corr_end got=to%b d%b f%b b%b exp=to0 d1 f0 b0",
                     to, done, fail, busy);
        end
        checks++;
        if (step_count !== 10'd13) begin
            failures++;
            $display("FAIL corr_steps got=%0d exp=13", step_count);
        end
        bad = 0;
        for (int i = 0; i < 14; i++)
            if (i >= em_q.size() || em_q[i] !== {4'(i + 1), 4'd1}) bad++;
        checks++;
        if (em_q.size() != 14 || bad != 0) begin
            failures++;
            $display("FAIL corr_seq got=n%0d bad%0d exp=n14 bad0",
                     em_q.size(), bad);
        end
`ifdef MAZE_TRACE_MAP_EN
        checks++;
        if (visited_map !== corridor_map()) begin
            failures++;
            $display("FAIL corr_visited got=%h exp=%h",
                     visited_map, corridor_map());
        end
`endif
    endtask

    task automatic test_dead_end();
        bit to;
        int bad;
        logic [7:0] exp_seq[9];
        logic [255:0] m;
        exp_seq = '{8'h11, 8'h12, 8'h13, 8'h12, 8'h11,
                    8'h12, 8'h13, 8'h12, 8'h11};
        m = set_cell(set_cell(set_cell('0, 1, 1), 1, 2), 1, 3);
        do_reset();
        pulse_start(m, 4'd5, 4'd5);
        wait_end(1'b1, 200, to);
        checks++;
        if (to || fail8 !== 1'b1 || done8 !== 1'b0) begin
            failures++;
            $display("FAIL dead_end got=to%b f%b d%b exp=to0 f1 d0",
                     to, fail8, done8);
        end
        checks++;
        if (step_count8 !== 10'd8) begin
            failures++;
            $display("FAIL dead_steps got=%0d exp=8", step_count8);
        end
        bad = 0;
        for (int i = 0; i < 9; i++)
            if (i >= em8_q.size() || em8_q[i] !== exp_seq[i]) bad++;
        checks++;
        if (em8_q.size() != 9 || bad != 0) begin
            failures++;
            $display("FAIL dead_seq got=n%0d bad%0d exp=n9 bad0",
                     em8_q.size(), bad);
        end
    endtask

    task automatic test_bad_start();
        do_reset();
        pulse_start('0, 4'd3, 4'd3);
        @(negedge clk);
        checks++;
        if (fail !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL bad_load got=f%b b%b exp=f0 b1", fail, busy);
        end
        @(negedge clk);
        checks++;
        if (fail !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL bad_fail got=f%b b%b d%b exp=f1 b0 d0",
                     fail, busy, done);
        end
        tick(); tick();
        checks++;
        if (em_q.size() != 0 || step_count !== 10'd0) begin
            failures++;
            $display("FAIL bad_noemit got=n%0d s%0d exp=n0 s0",
                     em_q.size(), step_count);
        end
    endtask

    task automatic test_backpressure();
        bit to;
        int bad;
        logic [7:0] hx;
        logic [9:0] hs;
        do_reset();
        pulse_start(corridor_map(), 4'd14, 4'd1);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (em_q.size() >= 3) break;
        end
        tick();
        pos_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (pos_valid) break;
        end
        hx = {pos_x, pos_y};
        hs = step_count;
        checks++;
        if (hx !== 8'h41 || hs !== 10'd3 || pos_valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_hold_cell got=%h s%0d v%b exp=41 s3 v1",
                     hx, hs, pos_valid);
        end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if ({pos_x, pos_y} !== hx || step_count !== hs || !pos_valid)
                bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL bp_stable got=%0d exp=0", bad);
        end
        tick();
        pos_ready = 1'b1;
        wait_end(1'b0, 300, to);
        bad = 0;
        for (int i = 0; i < 14; i++)
            if (i >= em_q.size() || em_q[i] !== {4'(i + 1), 4'd1}) bad++;
        checks++;
        if (to || done !== 1'b1 || step_count !== 10'd13 ||
            em_q.size() != 14 || bad != 0) begin
            failures++;
            $display("FAIL bp_seq got=to%b d%b s%0d n%0d bad%0d exp=0 1 13 14 0",
                     to, done, step_count, em_q.size(), bad);
        end
    endtask

    task automatic test_ring();
        bit to;
        int bad, edges;
        logic [7:0] exp_seq[9];
        logic [255:0] m;
        exp_seq = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15,
                    8'h25, 8'h35, 8'h45, 8'h55};
        m = '0;
        for (int i = 0; i < 16; i++) begin
            m = set_cell(m, i, 0);  m = set_cell(m, i, 15);
            m = set_cell(m, 0, i);  m = set_cell(m, 15, i);
        end
        for (int y = 1; y <= 5; y++)
            for (int x = 1; x <= 5; x++)
                if (x == 1 || x == 5 || y == 1 || y == 5)
                    m = set_cell(m, x, y);
        do_reset();
        pulse_start(m, 4'd5, 4'd5);
        wait_end(1'b0, 300, to);
        checks++;
        if (to || done !== 1'b1 || fail !== 1'b0 || step_count !== 10'd8) begin
            failures++;
            $display("FAIL ring_end got=to%b d%b f%b s%0d exp=to0 d1 f0 s8",
                     to, done, fail, step_count);
        end
        bad = 0;
        edges = 0;
        foreach (em_q[i]) begin
            if (em_q[i][7:4] == 4'd0 || em_q[i][7:4] == 4'd15 ||
                em_q[i][3:0] == 4'd0 || em_q[i][3:0] == 4'd15) edges++;
            if (i >= 9 || em_q[i] !== exp_seq[i]) bad++;
        end
        checks++;
        if (edges != 0) begin
            failures++;
            $display("FAIL ring_border got=%0d exp=0", edges);
        end
        checks++;
        if (em_q.size() != 9 || bad != 0) begin
            failures++;
            $display("FAIL ring_seq got=n%0d bad%0d exp=n9 bad0",
                     em_q.size(), bad);
        end
    endtask

    task automatic test_goal_is_start();
        bit to;
        do_reset();
        pulse_start(corridor_map(), 4'd1, 4'd1);
        wait_end(1'b0, 50, to);
        checks++;
        if (to || done !== 1'b1 || step_count !== 10'd0 || em_q.size() != 1) begin
            failures++;
            $display("FAIL goal_start got=to%b d%b s%0d n%0d exp=to0 d1 s0 n1",
                     to, done, step_count, em_q.size());
        end
    endtask

    task automatic test_reset_mid_run();
        bit to;
        do_reset();
        pulse_start(corridor_map(), 4'd14, 4'd1);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (em_q.size() >= 4) break;
        end
        tick();
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        checks++;
        if ({busy, done, fail, pos_valid} !== 4'b0 || {pos_x, pos_y} !== 8'h00 ||
            step_count !== 10'd0) begin
            failures++;
            $display("FAIL midrst_zero got=%b %h s%0d exp=0000 00 s0",
                     {busy, done, fail, pos_valid}, {pos_x, pos_y}, step_count);
        end
        rst_n = 1'b1;
        tick();
        em_q.delete();
        pulse_start(corridor_map(), 4'd14, 4'd1);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (pos_valid !== 1'b1 || {pos_x, pos_y} !== 8'h11 ||
            step_count !== 10'd0) begin
            failures++;
            $display("FAIL midrst_restart got=v%b %h s%0d exp=v1 11 s0",
                     pos_valid, {pos_x, pos_y}, step_count);
        end
        wait_end(1'b0, 300, to);
        checks++;
        if (to || done !== 1'b1 || step_count !== 10'd13 || em_q.size() != 14) begin
            failures++;
            $display("FAIL midrst_end got=to%b d%b s%0d n%0d exp=to0 d1 s13 n14",
                     to, done, step_count, em_q.size());
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; pos_ready = 1'b1;
        maze_data = '0; goal_x = '0; goal_y = '0;
        test_reset();
        test_corridor();
        test_dead_end();
        test_bad_start();
        test_backpressure();
        test_ring();
        test_goal_is_start();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
